br_resolve_tracker: RTL and testbench

Tracks in-flight conditional-branch predictions from decode until resolution at writeback in the LC-3b pipeline. At resolution it compares the recorded prediction with the actual outcome, drives the pattern-history-table write port, and raises a one-cycle mispredict/redirect to fetch. It also keeps saturating branch and mispredict counters. It is the update and recovery side of the branch predictor.

---
 rtl/br_resolve_tracker_if.sv | 47 ++++
 rtl/br_resolve_tracker.sv | 123 ++++++++++++
 tb/tb_br_resolve_tracker.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/br_resolve_tracker_if.sv
// Branch tracker bus: decode-side enqueue, writeback-side resolve,
// and the PHT update / fetch redirect / statistics outputs.
interface br_resolve_tracker_if #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             enq_valid;
    logic [15:0]      enq_pc;
    logic             enq_pred_taken;
    logic [15:0]      enq_pred_target;
    logic             enq_ready;

    logic             res_valid;
    logic [15:0]      res_pc;
    logic             res_taken;
    logic [15:0]      res_target;

    logic             ext_flush;

    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             mispredict;
    logic [15:0]      redirect_pc;
    logic [CNT_W-1:0] count;
    logic [15:0]      stat_branches;
    logic [15:0]      stat_mispredicts;
    logic             protocol_err;

    // Pipeline side: drives branches in and resolutions, observes results
    modport master (
        output enq_valid, enq_pc, enq_pred_taken, enq_pred_target,
        output res_valid, res_pc, res_taken, res_target, ext_flush,
        input  enq_ready, upd_valid, upd_index, upd_taken, mispredict,
        input  redirect_pc, count, stat_branches, stat_mispredicts, protocol_err
    );

    // Tracker side
    modport slave (
        input  enq_valid, enq_pc, enq_pred_taken, enq_pred_target,
        input  res_valid, res_pc, res_taken, res_target, ext_flush,
        output enq_ready, upd_valid, upd_index, upd_taken, mispredict,
        output redirect_pc, count, stat_branches, stat_mispredicts, protocol_err
    );
endinterface

// File: rtl/br_resolve_tracker.sv
// In-flight conditional-branch tracker: holds predictions from decode in a
// circular FIFO, checks them at writeback, updates the PHT and redirects
// fetch on a mispredict. Also keeps saturating branch/mispredict counters.
module br_resolve_tracker #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    br_resolve_tracker_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; contents are only meaningful for occupied slots
    logic [15:0]      pc_mem  [DEPTH];
    logic             pt_mem  [DEPTH];
    logic [15:0]      tgt_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_r;
    logic             enq_ready_c;

    logic             res_ok;
    logic             mis_c;
    logic             enq_do;
    logic             squash;
    logic [15:0]      redirect_c;

    logic             upd_valid_r;
    logic [IDX_W-1:0] upd_index_r;
    logic             upd_taken_r;
    logic             mispredict_r;
    logic [15:0]      redirect_r;
    logic [15:0]      stat_br_r;
    logic [15:0]      stat_mis_r;
    logic             perr_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign enq_ready_c = (count_r != CNT_W'(DEPTH));

    // Resolve qualification, mispredict detection and next-PC selection
    always_comb begin
        res_ok     = 1'b0;
        mis_c      = 1'b0;
        redirect_c = bus.res_taken ? bus.res_target : bus.res_pc + 16'd2;
        if (bus.res_valid && (count_r != '0) && (bus.res_pc == pc_mem[rd_ptr])) begin
            res_ok = 1'b1;
            mis_c  = (pt_mem[rd_ptr] != bus.res_taken) ||
                     (bus.res_taken && (tgt_mem[rd_ptr] != bus.res_target));
        end
        // Anything younger than a mispredicting head, or any flush, kills the enqueue
        squash = bus.ext_flush || mis_c;
        enq_do = bus.enq_valid && enq_ready_c && !squash;
    end

    // Entry write on an accepted, surviving enqueue
    always_ff @(posedge clk) begin
        if (enq_do) begin
            pc_mem[wr_ptr]  <= bus.enq_pc;
            pt_mem[wr_ptr]  <= bus.enq_pred_taken;
            tgt_mem[wr_ptr] <= bus.enq_pred_target;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else if (squash) begin
            rd_ptr  <= wr_ptr;
            count_r <= '0;
        end else begin
            if (enq_do) wr_ptr <= wr_ptr + PTR_W'(1);
            if (res_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            count_r <= count_r + CNT_W'(enq_do) - CNT_W'(res_ok);
        end
    end

    // Registered PHT update, redirect, statistics and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_r  <= 1'b0;
            upd_index_r  <= '0;
            upd_taken_r  <= 1'b0;
            mispredict_r <= 1'b0;
            redirect_r   <= '0;
            stat_br_r    <= '0;
            stat_mis_r   <= '0;
            perr_r       <= 1'b0;
        end else begin
            upd_valid_r  <= res_ok;
            mispredict_r <= mis_c;
            if (res_ok) begin
                upd_index_r <= bus.res_pc[IDX_W-1:0];
                upd_taken_r <= bus.res_taken;
                stat_br_r   <= sat_inc(stat_br_r);
            end
            if (mis_c) begin
                redirect_r <= redirect_c;
                stat_mis_r <= sat_inc(stat_mis_r);
            end
            if (bus.res_valid && !res_ok) perr_r <= 1'b1;
        end
    end

    assign bus.enq_ready        = enq_ready_c;
    assign bus.count            = count_r;
    assign bus.upd_valid        = upd_valid_r;
    assign bus.upd_index        = upd_index_r;
    assign bus.upd_taken        = upd_taken_r;
    assign bus.mispredict       = mispredict_r;
    assign bus.redirect_pc      = redirect_r;
    assign bus.stat_branches    = stat_br_r;
    assign bus.stat_mispredicts = stat_mis_r;
    assign bus.protocol_err     = perr_r;
endmodule

// File: tb/tb_br_resolve_tracker.sv
// Bench for br_resolve_tracker: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_br_resolve_tracker;
    localparam int DEPTH = 4;
    localparam int IDX_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    br_resolve_tracker_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    br_resolve_tracker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] pc;
        logic        pt;
        logic [15:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_stat_b, m_stat_m, m_redir;
    logic [7:0]  m_idx;
    logic        m_upd, m_tk, m_mis, m_perr;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_stat_b = 0; m_stat_m = 0; m_redir = 0; m_idx = 0;
        m_upd = 0; m_tk = 0; m_mis = 0; m_perr = 0;
    endtask

    task automatic idle_inputs();
        bus.enq_valid = 0; bus.enq_pc = 0; bus.enq_pred_taken = 0; bus.enq_pred_target = 0;
        bus.res_valid = 0; bus.res_pc = 0; bus.res_taken = 0; bus.res_target = 0;
        bus.ext_flush = 0;
    endtask

    task automatic check_all();
        check("count", bus.count, q.size());
        check("enq_ready", bus.enq_ready, q.size() != DEPTH);
        check("upd_valid", bus.upd_valid, m_upd);
        check("mispredict", bus.mispredict, m_mis);
        check("protocol_err", bus.protocol_err, m_perr);
        check("stat_branches", bus.stat_branches, m_stat_b);
        check("stat_mispredicts", bus.stat_mispredicts, m_stat_m);
        if (m_upd) begin
            check("upd_index", bus.upd_index, m_idx);
            check("upd_taken", bus.upd_taken, m_tk);
        end
        if (m_mis) check("redirect_pc", bus.redirect_pc, m_redir);
    endtask

    // One clock: capture inputs, let the edge happen, advance the model, compare.
    task automatic tick();
        bit ready, ok, mis, ev, fl, rv, rt;
        logic [15:0] rpc, rtg;
        ent_t e, h;
        ready = (q.size() != DEPTH);
        ev = bus.enq_valid; e.pc = bus.enq_pc; e.pt = bus.enq_pred_taken; e.tgt = bus.enq_pred_target;
        rv = bus.res_valid; rpc = bus.res_pc; rt = bus.res_taken; rtg = bus.res_target;
        fl = bus.ext_flush;
        ok = 0; mis = 0;
        if (rv && q.size() != 0) begin
            h = q[0];
            if (h.pc == rpc) begin
                ok = 1;
                mis = (h.pt != rt) || (rt && h.tgt != rtg);
            end
        end
        @(posedge clk); #1;
        m_upd = ok;
        m_mis = mis;
        if (rv && !ok) m_perr = 1;
        if (ok) begin
            m_idx = rpc[7:0];
            m_tk = rt;
            if (m_stat_b != 16'hFFFF) m_stat_b++;
            void'(q.pop_front());
        end
        if (mis) begin
            m_redir = rt ? rtg : rpc + 16'd2;
            if (m_stat_m != 16'hFFFF) m_stat_m++;
        end
        if (mis || fl) q.delete();
        else if (ev && ready) q.push_back(e);
        check_all();
    endtask

    task automatic enq(input logic [15:0] pc, input logic pt, input logic [15:0] tgt);
        idle_inputs();
        bus.enq_valid = 1; bus.enq_pc = pc; bus.enq_pred_taken = pt; bus.enq_pred_target = tgt;
        tick();
        idle_inputs();
    endtask

    task automatic res(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        idle_inputs();
        bus.res_valid = 1; bus.res_pc = pc; bus.res_taken = tk; bus.res_target = tgt;
        tick();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        logic [15:0] a;
        model_reset();
        idle_inputs();
        do_reset();

        // Reset state
        check("rst_count", bus.count, 0);
        check("rst_enq_ready", bus.enq_ready, 1);
        check("rst_upd_valid", bus.upd_valid, 0);
        check("rst_upd_index", bus.upd_index, 0);
        check("rst_upd_taken", bus.upd_taken, 0);
        check("rst_mispredict", bus.mispredict, 0);
        check("rst_redirect", bus.redirect_pc, 0);
        check("rst_perr", bus.protocol_err, 0);
        check("rst_stat_b", bus.stat_branches, 0);
        check("rst_stat_m", bus.stat_mispredicts, 0);

        // Resolve while empty
        res(16'h1234, 0, 0);
        check("empty_perr", bus.protocol_err, 1);
        check("empty_upd", bus.upd_valid, 0);
        check("empty_count", bus.count, 0);

        // Correct not-taken
        enq(16'h3000, 0, 16'h0000);
        res(16'h3000, 0, 16'h0000);
        check("nt_upd_valid", bus.upd_valid, 1);
        check("nt_upd_index", bus.upd_index, 8'h00);
        check("nt_upd_taken", bus.upd_taken, 0);
        check("nt_mis", bus.mispredict, 0);
        check("nt_stat_b", bus.stat_branches, 1);

        // Direction mispredict squashes younger entries
        enq(16'h3010, 0, 16'h0000);
        enq(16'h3020, 0, 16'h0000);
        enq(16'h3030, 0, 16'h0000);
        res(16'h3010, 1, 16'h3100);
        check("dir_mis", bus.mispredict, 1);
        check("dir_redirect", bus.redirect_pc, 16'h3100);
        check("dir_count", bus.count, 0);
        check("dir_stat_m", bus.stat_mispredicts, 1);
        tick();
        check("dir_pulse_once", bus.mispredict, 0);

        // Target mispredict
        enq(16'h3040, 1, 16'h3050);
        res(16'h3040, 1, 16'h3060);
        check("tgt_mis", bus.mispredict, 1);
        check("tgt_redirect", bus.redirect_pc, 16'h3060);
        check("tgt_upd_taken", bus.upd_taken, 1);

        // Fill, enqueue dropped while full, then overlapped traffic across the wrap
        for (int i = 0; i < DEPTH; i++) enq(16'h5000 + 16'(2 * i), 0, 16'h0000);
        check("full_ready", bus.enq_ready, 0);
        idle_inputs();
        bus.enq_valid = 1; bus.enq_pc = 16'h5555;
        bus.res_valid = 1; bus.res_pc = 16'h5000; bus.res_taken = 0;
        tick();
        check("full_drop_count", bus.count, DEPTH - 1);
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            bus.enq_valid = 1; bus.enq_pc = 16'h6000 + 16'(2 * i);
            bus.res_valid = 1; bus.res_pc = q[0].pc; bus.res_taken = 0;
            tick();
            check("wrap_count", bus.count, DEPTH - 1);
        end
        while (q.size() != 0) res(q[0].pc, 0, 0);

        // Not-taken mispredict wraps PC+2
        enq(16'hFFFE, 1, 16'h1000);
        res(16'hFFFE, 0, 16'h0000);
        check("wrap_redirect", bus.redirect_pc, 16'h0000);
        check("wrap_mis", bus.mispredict, 1);

        // ext_flush drops a same-cycle enqueue
        enq(16'h4000, 0, 16'h0000);
        idle_inputs();
        bus.ext_flush = 1; bus.enq_valid = 1; bus.enq_pc = 16'h4002;
        tick();
        check("flush_count", bus.count, 0);

        // Random traffic, with an asynchronous reset in the middle of a mispredict
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            bus.enq_valid = ($urandom_range(0, 99) < 60);
            bus.enq_pc = 16'($urandom_range(0, 15) * 2) + 16'h7000;
            bus.enq_pred_taken = 1'($urandom_range(0, 1));
            bus.enq_pred_target = 16'h7100 + 16'($urandom_range(0, 1) * 4);
            if ($urandom_range(0, 99) < 50) begin
                bus.res_valid = 1;
                if (q.size() != 0 && $urandom_range(0, 99) < 95) begin
                    bus.res_pc = q[0].pc;
                    bus.res_taken = ($urandom_range(0, 99) < 80) ? q[0].pt : ~q[0].pt;
                    bus.res_target = ($urandom_range(0, 99) < 80) ? q[0].tgt : 16'h7180;
                end else begin
                    a = 16'($urandom);
                    bus.res_pc = a;
                    bus.res_taken = a[0];
                    bus.res_target = a ^ 16'h00F0;
                end
            end
            bus.ext_flush = ($urandom_range(0, 99) < 3);
            tick();
            if (c == 1500) begin
                // Force a mispredict pulse, then reset asynchronously while it is high
                idle_inputs();
                while (q.size() != 0) res(q[0].pc, q[0].pt, q[0].tgt);
                enq(16'h7ABC, 0, 16'h0000);
                res(16'h7ABC, 1, 16'h7DEF);
                check("pre_rst_mis", bus.mispredict, 1);
                rst_n = 0;
                #2;
                check("async_rst_mis", bus.mispredict, 0);
                check("async_rst_count", bus.count, 0);
                check("async_rst_stat_m", bus.stat_mispredicts, 0);
                #1;
                rst_n = 1;
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
